// File: rtl/ariane_pkg.sv
// Shared pipeline types for the execute / write-back boundary.
package ariane_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned NR_WB_SRC = 4;

    typedef enum logic [1:0] {
        WB_SRC_FLU   = 2'd0,
        WB_SRC_LOAD  = 2'd1,
        WB_SRC_STORE = 2'd2,
        WB_SRC_FPU   = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [riscv::XLEN-1:0] cause;
        logic [riscv::XLEN-1:0] tval;
        logic                   valid;
    } exception_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [riscv::XLEN-1:0]   result;
        exception_t               ex;
    } wb_entry_t;
endpackage

// File: rtl/riscv.sv
// Base RISC-V architectural constants shared by the pipeline.
package riscv;
    localparam int unsigned XLEN = 64;
endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO; a push into a full FIFO is dropped unless
// the head is popped at the same edge.
module wb_src_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  entry_t                       data_i,
    output entry_t                       data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = data_i;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_merge_unit.sv
// Merges the non-stallable execute result channels onto the scoreboard
// write-back ports through per-source FIFOs and a round-robin arbiter.
module wb_merge_unit
    import ariane_pkg::*;
#(
    parameter int unsigned NR_SRC     = NR_WB_SRC,
    parameter int unsigned NR_WB      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic [NR_SRC-1:0]                      src_valid_i,
    input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]   src_trans_id_i,
    input  logic [NR_SRC-1:0][riscv::XLEN-1:0]     src_result_i,
    input  exception_t [NR_SRC-1:0]                src_ex_i,
    output logic [NR_WB-1:0]                       wb_valid_o,
    output logic [NR_WB-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_o,
    output logic [NR_WB-1:0][riscv::XLEN-1:0]      wb_result_o,
    output exception_t [NR_WB-1:0]                 wb_ex_o,
    output logic                                   stall_issue_o,
    output logic                                   overflow_o
);
    localparam int unsigned PW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t [NR_SRC-1:0]        head;
    logic [NR_SRC-1:0]             empty, full, push, pop;
    logic [NR_SRC-1:0][CW-1:0]     count;
    logic [PW-1:0]                 p_q, p_d;
    logic                          ovf_q, ovf_d;
    int                            n_gnt;

    // Results arriving during a flush belong to squashed instructions.
    assign push = flush_i ? '0 : src_valid_i;

    for (genvar s = 0; s < NR_SRC; s++) begin : g_src
        wb_entry_t din;
        assign din = '{
            trans_id: src_trans_id_i[s],
            result:   src_result_i[s],
            ex:       src_ex_i[s]
        };
        wb_src_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .entry_t    (wb_entry_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (push[s]),
            .pop_i   (pop[s]),
            .data_i  (din),
            .data_o  (head[s]),
            .empty_o (empty[s]),
            .full_o  (full[s]),
            .count_o (count[s])
        );
    end

    always_comb begin
        pop           = '0;
        wb_valid_o    = '0;
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_o       = '0;
        p_d           = p_q;
        n_gnt         = 0;
        if (flush_i) begin
            p_d = '0;
        end else begin
            // Scan p, p+1, ... and hand out ports in scan order.
            for (int i = 0; i < NR_SRC; i++) begin
                for (int s = 0; s < NR_SRC; s++) begin
                    if (((int'(p_q) + i) % NR_SRC) == s && !empty[s]
                        && n_gnt < NR_WB) begin
                        pop[s] = 1'b1;
                        for (int k = 0; k < NR_WB; k++) begin
                            if (k == n_gnt) begin
                                wb_valid_o[k]    = 1'b1;
                                wb_trans_id_o[k] = head[s].trans_id;
                                wb_result_o[k]   = head[s].result;
                                wb_ex_o[k]       = head[s].ex;
                            end
                        end
                        n_gnt = n_gnt + 1;
                        p_d   = PW'((s + 1) % NR_SRC);
                    end
                end
            end
        end
    end

    always_comb begin
        stall_issue_o = 1'b0;
        ovf_d         = ovf_q;
        for (int s = 0; s < NR_SRC; s++) begin
            if (count[s] >= CW'(FIFO_DEPTH - 1)) begin
                stall_issue_o = 1'b1;
            end
            if (push[s] && full[s] && !pop[s]) begin
                ovf_d = 1'b1;
            end
        end
        if (flush_i) begin
            ovf_d = 1'b0;
        end
    end

    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for the write-back merge unit.
module tb_wb_merge_unit;
    import ariane_pkg::*;

    logic clk, rst_n, flush;
    logic [3:0] sv;
    logic [3:0][2:0] sid;
    logic [3:0][63:0] sres;
    exception_t [3:0] sex;
    logic [1:0] wv;
    logic [1:0][2:0] wid;
    logic [1:0][63:0] wres;
    exception_t [1:0] wex;
    logic stall, ovf;
    int n_chk, n_fail;
    exception_t ex_ref;

    wb_merge_unit #(.NR_SRC(4), .NR_WB(2), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .src_valid_i(sv), .src_trans_id_i(sid),
        .src_result_i(sres), .src_ex_i(sex),
        .wb_valid_o(wv), .wb_trans_id_o(wid),
        .wb_result_o(wres), .wb_ex_o(wex),
        .stall_issue_o(stall), .overflow_o(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sv = '0; sid = '0; sres = '0; sex = '0;
    endtask

    task automatic do_reset();
        idle_in();
        flush = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (wv !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", wv); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_chk++; if (wid !== '0 || wres !== '0 || wex !== '0) begin n_fail++; $display("FAIL reset_data: got id %h res %h want 0", wid, wres); end
        #3 rst_n = 1'b1;
        tick();
        n_chk++; if (wv !== 2'b00) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 00", wv); end
    endtask

    task automatic test_single_load();
        do_reset();
        ex_ref = '{cause: 64'd5, tval: 64'h1234, valid: 1'b1};
        sv = 4'b0010; sid[1] = 3'd3; sres[1] = 64'hDEAD_BEEF; sex[1] = ex_ref;
        tick();
        idle_in();
        n_chk++; if (wv !== 2'b01) begin n_fail++; $display("FAIL single_valid: got %b want 01", wv); end
        n_chk++; if (wid[0] !== 3'd3) begin n_fail++; $display("FAIL single_id: got %0d want 3", wid[0]); end
        n_chk++; if (wres[0] !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL single_res: got %h want deadbeef", wres[0]); end
        n_chk++; if (wex[0] !== ex_ref) begin n_fail++; $display("FAIL single_ex: got %h want %h", wex[0], ex_ref); end
        n_chk++; if (wid[1] !== '0 || wres[1] !== '0 || wex[1] !== '0) begin n_fail++; $display("FAIL single_port1_zero: got id %0d res %h want 0", wid[1], wres[1]); end
        tick();
        n_chk++; if (wv !== 2'b00 || wres[0] !== '0 || wid[0] !== '0) begin n_fail++; $display("FAIL single_idle: got v %b res %h want 00/0", wv, wres[0]); end
    endtask

    task automatic test_all_four();
        do_reset();
        for (int s = 0; s < 4; s++) begin
            sid[s] = 3'(s + 1); sres[s] = 64'h100 + 64'(s);
        end
        sv = 4'b1111;
        tick();
        idle_in();
        n_chk++; if (wv !== 2'b11) begin n_fail++; $display("FAIL four_c1_valid: got %b want 11", wv); end
        n_chk++; if (wid[0] !== 3'd1 || wid[1] !== 3'd2) begin n_fail++; $display("FAIL four_c1_ids: got %0d,%0d want 1,2", wid[0], wid[1]); end
        n_chk++; if (wres[1] !== 64'h101) begin n_fail++; $display("FAIL four_c1_res: got %h want 101", wres[1]); end
        tick();
        n_chk++; if (wv !== 2'b11 || wid[0] !== 3'd3 || wid[1] !== 3'd4) begin n_fail++; $display("FAIL four_c2: got v %b ids %0d,%0d want 11 3,4", wv, wid[0], wid[1]); end
        tick();
        n_chk++; if (wv !== 2'b00) begin n_fail++; $display("FAIL four_c3_valid: got %b want 00", wv); end
        sv = 4'b1001; sid[0] = 3'd6; sid[3] = 3'd5;
        tick();
        idle_in();
        n_chk++; if (wid[0] !== 3'd6 || wid[1] !== 3'd5) begin n_fail++; $display("FAIL four_ptr_wrap: got %0d,%0d want 6,5", wid[0], wid[1]); end
        tick();
    endtask

    task automatic test_fair();
        logic [2:0] f;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            f = 3'(i);
            sv = 4'b0011; sid[0] = f; sid[1] = ~f;
            tick();
            n_chk++; if (wv !== 2'b11 || wid[0] !== f || wid[1] !== ~f) begin n_fail++; $display("FAIL fair_%0d: got v %b ids %0d,%0d want 11 %0d,%0d", i, wv, wid[0], wid[1], f, ~f); end
            n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fair_stall_%0d: got %b want 0", i, stall); end
        end
        idle_in();
        tick();
        n_chk++; if (wv !== 2'b00) begin n_fail++; $display("FAIL fair_drain: got %b want 00", wv); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            idle_in();
            sv = (k % 2 == 1) ? 4'b1111 : 4'b1000;
            sid[3] = 3'(k - 1); sres[3] = 64'hF00 + 64'(k);
            tick();
            if (k == 3) begin n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ovf_stall_lo: got %b want 0", stall); end end
            if (k == 4) begin n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ovf_stall_hi: got %b want 1", stall); end end
            if (k == 7) begin n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop_full: got %b want 0", ovf); end end
            if (k == 8) begin n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf); end end
        end
        idle_in();
        n_chk++; if (wv !== 2'b11 || wid[1] !== 3'd3 || wres[1] !== 64'hF04) begin n_fail++; $display("FAIL ovf_drain0: got v %b id %0d res %h want 11 3 f04", wv, wid[1], wres[1]); end
        tick();
        n_chk++; if (wv !== 2'b01 || wid[0] !== 3'd4 || wres[0] !== 64'hF05) begin n_fail++; $display("FAIL ovf_drain1: got v %b id %0d res %h want 01 4 f05", wv, wid[0], wres[0]); end
        tick();
        n_chk++; if (wid[0] !== 3'd5 || stall !== 1'b0) begin n_fail++; $display("FAIL ovf_drain2: got id %0d stall %b want 5 0", wid[0], stall); end
        tick();
        n_chk++; if (wid[0] !== 3'd6 || wres[0] !== 64'hF07) begin n_fail++; $display("FAIL ovf_drain3: got id %0d res %h want 6 f07", wid[0], wres[0]); end
        tick();
        n_chk++; if (wv !== 2'b00 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got v %b ovf %b want 00 1", wv, ovf); end
    endtask

    // Runs straight after test_overflow so overflow_o starts set.
    task automatic test_flush();
        n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL flush_pre_ovf: got %b want 1", ovf); end
        sv = 4'b0010; sid[1] = 3'd1;
        tick();
        idle_in();
        n_chk++; if (wv !== 2'b01 || wid[0] !== 3'd1) begin n_fail++; $display("FAIL flush_pre1: got v %b id %0d want 01 1", wv, wid[0]); end
        sv = 4'b0111; sid[0] = 3'd5; sid[1] = 3'd6; sid[2] = 3'd7;
        tick();
        idle_in();
        n_chk++; if (wv !== 2'b11 || wid[0] !== 3'd7 || wid[1] !== 3'd5) begin n_fail++; $display("FAIL flush_pre2: got v %b ids %0d,%0d want 11 7,5", wv, wid[0], wid[1]); end
        flush = 1'b1; sv = 4'b0001; sid[0] = 3'd2;
        #1;
        n_chk++; if (wv !== 2'b00 || wid !== '0) begin n_fail++; $display("FAIL flush_mask: got v %b ids %h want 00 0", wv, wid); end
        tick();
        flush = 1'b0;
        idle_in();
        n_chk++; if (wv !== 2'b00 || ovf !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got v %b ovf %b stall %b want 00 0 0", wv, ovf, stall); end
        sv = 4'b1010; sid[1] = 3'd3; sid[3] = 3'd2;
        tick();
        idle_in();
        n_chk++; if (wid[0] !== 3'd3 || wid[1] !== 3'd2) begin n_fail++; $display("FAIL flush_ptr: got %0d,%0d want 3,2", wid[0], wid[1]); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int s = 0; s < 4; s++) sid[s] = 3'(s + 1);
        sv = 4'b1111;
        tick();
        idle_in();
        n_chk++; if (wv !== 2'b11) begin n_fail++; $display("FAIL arst_pre: got %b want 11", wv); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (wv !== 2'b00 || wid !== '0) begin n_fail++; $display("FAIL arst_async: got v %b ids %h want 00 0", wv, wid); end
        rst_n = 1'b1;
        tick();
        n_chk++; if (wv !== 2'b00) begin n_fail++; $display("FAIL arst_empty: got %b want 00", wv); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; flush = 1'b0;
        idle_in();
        test_reset();
        test_single_load();
        test_all_four();
        test_fair();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
- Sits directly downstream of the execute stage and upstream of the scoreboard write-back ports.
- Collects results from four execute-stage result channels: FLU, load, store and FPU. None of these channels can be back-pressured.
- Buffers each channel in a small per-source FIFO and merges them onto NR_WB scoreboard write ports using round-robin arbitration.
- Asks the issue stage to stall before any FIFO can overflow.

Parameters:
- NR_SRC, 4, number of result sources; index 0=FLU, 1=load, 2=store, 3=FPU.
- NR_WB, 2, number of scoreboard write-back ports produced.
- FIFO_DEPTH, 4, entries per source FIFO; must be a power of two, minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock domain; reset is asynchronous and active-low
- flush_i  in  1  pipeline flush; discards all buffered results
- src_valid_i  in  NR_SRC  result valid per source
- src_trans_id_i  in  NR_SRC x TRANS_ID_BITS  scoreboard id per source
- src_result_i  in  NR_SRC x riscv::XLEN  result data per source
- src_ex_i  in  NR_SRC x exception_t  exception per source; passed through unchanged
- wb_valid_o  out  NR_WB  write-back valid per port
- wb_trans_id_o  out  NR_WB x TRANS_ID_BITS  scoreboard id per port
- wb_result_o  out  NR_WB x riscv::XLEN  data per port
- wb_ex_o  out  NR_WB x exception_t  exception per port
- stall_issue_o  out  1  asks the issue stage to stop issuing
- overflow_o  out  1  sticky error: a result was dropped

Behaviour:
- Reset values:
  - All FIFOs empty; round-robin pointer p=0.
  - overflow_o=0, stall_issue_o=0.
  - wb_* outputs all 0.
- Output data rule: whenever wb_valid_o[k]=0, wb_trans_id_o[k], wb_result_o[k] and wb_ex_o[k] are driven to 0.
- Push:
  - src_valid_i[s]=1 at rising edge N writes {trans_id, result, ex} into FIFO s.
  - No bypass: the entry is visible at the outputs from cycle N+1. Minimum latency is 1 cycle.
- Outputs:
  - Outputs are combinational from the FIFO heads and the grant decision; there is no output register.
  - Each scoreboard write is accepted unconditionally; no ready signal exists.
  - A granted head is popped at the same edge.
- Arbitration, each cycle:
  - Scan sources in order p, p+1, … (mod NR_SRC).
  - The first non-empty FIFO goes to wb port 0, the second to port 1, and so on, up to NR_WB grants.
  - If at least one grant is made, p takes (index of last granted source + 1) mod NR_SRC at the edge.
  - If no grant is made, p holds.
  - Order within one source is strict FIFO.
- Full FIFO, push and pop in the same cycle: allowed; count is unchanged; the new entry is written correctly.
- Full FIFO, push without pop: the entry is dropped and overflow_o is set. overflow_o stays set until reset or flush.
- Empty FIFO, push with no grant: count becomes 1.
- Pointer wrap-around: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. A separate count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- stall_issue_o: combinational; equals 1 when any FIFO count >= FIFO_DEPTH-1. This gives one cycle of slack for a result already in flight.
- Flush:
  - While flush_i=1, wb_valid_o is forced to 0 and no pops occur.
  - At the edge, all FIFOs clear, p returns to 0 and overflow_o clears.
  - src_valid_i in the flush cycle is ignored.
- Reset mid-operation: asynchronous clear to the reset values above, independent of the clock.
- Store entries have the same format as other entries: result is the store result and trans_id is the store id.

Decomposition:
- Shared package (ariane_pkg) contains:
  - wb_src_e enum: WB_SRC_FLU=0, WB_SRC_LOAD=1, WB_SRC_STORE=2, WB_SRC_FPU=3.
  - wb_entry_t struct: {trans_id, result, ex}.
  - Constant NR_WB_SRC=4.
- Sub-module wb_src_fifo:
  - Single-source FIFO with parameters FIFO_DEPTH and entry type wb_entry_t.
  - Ports: push, pop, flush, head data, empty, full, count.
  - The top instantiates NR_SRC copies and adds the arbiter, stall logic and overflow logic.

Test Plan:
- Reset with no inputs → wb_valid_o=00, stall_issue_o=0, overflow_o=0, all wb data 0.
- Single load result: trans_id=3, result=0xDEAD_BEEF at edge N → cycle N+1: wb_valid_o[0]=1, id 3, data 0xDEADBEEF; wb_valid_o[1]=0. Cycle N+2: all outputs idle.
- All four sources valid in one cycle with ids 1/2/3/4, p=0:
  - Cycle 1: ports carry ids 1,2; p becomes 2.
  - Cycle 2: ports carry ids 3,4; p becomes 0.
  - Cycle 3: no valid outputs.
- FLU pushes every cycle while a tie-breaking load pushes every cycle → grants alternate fairly. No FIFO reaches count 3, so stall_issue_o stays 0.
- Fill the FPU FIFO while the arbiter is blocked (other three sources continuously non-empty and holding both ports):
  - stall_issue_o rises when the count reaches 3.
  - A 5th push without a pop → overflow_o=1, the entry is lost and the earlier 4 entries drain in order.
- Three entries buffered, then flush_i=1 together with src_valid_i[0]=1 → wb_valid_o=00 in that cycle. Next cycle: FIFOs empty, overflow_o=0, p=0, nothing written back.
